// File: rtl/scroll_display_pkg.sv
// Shared types and helpers for the scrolling window display.
// Optional feature macro: SCROLL_PINGPONG_EN (adds the ping-pong states).
package scroll_display_pkg;

    // Fill character used for blanks, gaps and padding.
    localparam logic [7:0] DEFAULT_BLANK = 8'h20;

    // Load mode encodings; 2'b11 is reserved and treated as one-shot.
    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_LOOP     = 2'b01,
        MODE_PINGPONG = 2'b10
    } modeT;

    // Controller states; the ping-pong pair exists only in the macro build.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_STATIC     = 3'd1,
        ST_LEAD_HOLD  = 3'd2,
        ST_SCROLL     = 3'd3,
        ST_END_HOLD   = 3'd4,
        ST_DONE       = 3'd5
`ifdef SCROLL_PINGPONG_EN
        ,
        ST_REV_SCROLL = 3'd6,
        ST_START_HOLD = 3'd7
`endif
    } stateT;

    // Bits needed to hold any value from 0 to maxVal inclusive.
    function automatic int lenWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/scroll_window_display_if.sv
// Load handshake and window output bundle of the scrolling window display.
// master: the string source; slave: the scroller.
interface scroll_window_display_if #(
    parameter int BUF_CHARS = 10,
    parameter int WIN_CHARS = 4
);
    import scroll_display_pkg::*;

    logic                                load_valid;
    logic                                load_ready;
    logic [BUF_CHARS*8-1:0]              load_str;
    logic [lenWidth(BUF_CHARS)-1:0]      load_len;
    logic [1:0]                          load_mode;
    logic [WIN_CHARS*8-1:0]              win_ascii;
    logic                                busy;
    logic                                scroll_done;

    modport master (
        output load_valid, load_str, load_len, load_mode,
        input  load_ready, win_ascii, busy, scroll_done
    );

    modport slave (
        input  load_valid, load_str, load_len, load_mode,
        output load_ready, win_ascii, busy, scroll_done
    );

endinterface

// File: rtl/scroll_tick_gen.sv
// Step prescaler: one-cycle step pulse every STEP_CYCLES clocks, counted
// from the most recent restart (or from the previous step).
module scroll_tick_gen #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic step
);
    localparam int CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(STEP_CYCLES - 1);

    logic [CntW-1:0] cycleCnt;

    // NOTE: sequential state uses <= so every register samples pre-edge values; = would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cycleCnt <= '0;
        end else if (cycleCnt == LastCnt) begin
            cycleCnt <= '0;
        end else begin
            cycleCnt <= cycleCnt + 1'b1;
        end
    end

    // A restart in the same cycle as the last count cancels that step.
    assign step = (cycleCnt == LastCnt) && !restart && !reset;

endmodule

// File: rtl/scroll_window_display.sv
// Scrolling window display: holds a string of up to BUF_CHARS chars and
// shows a WIN_CHARS-wide packed-ASCII window (leftmost char in the MSB byte)
// that advances one char per step, in one-shot or loop mode.
// Optional feature macro: SCROLL_PINGPONG_EN (mode 2'b10 bounces back and forth).
// HOLD_STEPS must be at least 1.
module scroll_window_display
    import scroll_display_pkg::*;
#(
    parameter int         BUF_CHARS   = 10,
    parameter int         WIN_CHARS   = 4,
    parameter int         STEP_CYCLES = 25_000_000,
    parameter int         HOLD_STEPS  = 2,
    parameter int         GAP_CHARS   = 2,
    parameter logic [7:0] BLANK_CHAR  = DEFAULT_BLANK
) (
    input  logic               clk,
    input  logic               reset,
    scroll_window_display_if.slave bus
);
    localparam int LenW  = lenWidth(BUF_CHARS);
    localparam int OffW  = lenWidth(BUF_CHARS + GAP_CHARS);
    localparam int IdxW  = OffW + 1;
    localparam int HoldW = lenWidth(HOLD_STEPS);

    localparam logic [LenW-1:0]  MaxLen   = LenW'(BUF_CHARS);
    localparam logic [LenW-1:0]  WinLen   = LenW'(WIN_CHARS);
    localparam logic [IdxW-1:0]  WinIdx   = IdxW'(WIN_CHARS);
    localparam logic [HoldW-1:0] LastHold = HoldW'(HOLD_STEPS - 1);

    stateT                  state, nextState;
    modeT                   modeReg, nextMode;
    logic [BUF_CHARS*8-1:0] strReg, nextStr;
    logic [LenW-1:0]        lenReg, nextLen, clampLen;
    logic [OffW-1:0]        offset, nextOffset;
    logic [HoldW-1:0]       holdCnt, nextHold;
    logic [OffW-1:0]        period, lastOff, nextPeriod;
    logic [OffW-1:0]        fwdOffset;
    stateT                  fwdState;
    logic                   fwdWrap;
    logic                   wrapEvt, revZeroEvt;
    logic                   readyReg, loadFire, step;
    logic [WIN_CHARS*8-1:0] winReg, winNext;
    logic                   busyReg, busyNext, doneReg, doneNext;
    logic [IdxW-1:0]        srcIdx;
    logic [7:0]             chr;

    // Reserved mode 2'b11 (and 2'b10 without the macro) falls back to one-shot.
    function automatic modeT normMode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_LOOP;
`ifdef SCROLL_PINGPONG_EN
            2'b10:   return MODE_PINGPONG;
`endif
            default: return MODE_ONESHOT;
        endcase
    endfunction

    // Char idx of the string (char 0 in the MSB byte); blank past the buffer.
    function automatic logic [7:0] charAt(input logic [BUF_CHARS*8-1:0] str,
                                          input logic [IdxW-1:0]        idx);
        logic [7:0] c;
        c = BLANK_CHAR;
        for (int j = 0; j < BUF_CHARS; j++) begin
            if (idx == IdxW'(j)) c = str[(BUF_CHARS-1-j)*8 +: 8];
        end
        return c;
    endfunction

    assign loadFire = bus.load_valid && readyReg;
    assign clampLen = (bus.load_len > MaxLen) ? MaxLen : bus.load_len;
    assign period   = (modeReg == MODE_LOOP) ? OffW'(lenReg) + OffW'(GAP_CHARS) : OffW'(lenReg);
    assign lastOff  = OffW'(lenReg) - OffW'(WIN_CHARS);

    scroll_tick_gen #(
        .STEP_CYCLES(STEP_CYCLES)
    ) tickGen (
        .clk    (clk),
        .reset  (reset),
        .restart(loadFire),
        .step   (step)
    );

    // State, latched length/mode, offset and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            modeReg  <= MODE_ONESHOT;
            lenReg   <= '0;
            offset   <= '0;
            holdCnt  <= '0;
            readyReg <= 1'b0;
        end else begin
            state    <= nextState;
            modeReg  <= nextMode;
            lenReg   <= nextLen;
            offset   <= nextOffset;
            holdCnt  <= nextHold;
            readyReg <= 1'b1;
        end
    end

    // NOTE: the string buffer has no reset; lenReg clears to 0 on reset, which masks every byte from the window.
    always_ff @(posedge clk) begin
        if (loadFire) strReg <= bus.load_str;
    end

    // NOTE: every variable of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        nextState  = state;
        nextMode   = modeReg;
        nextStr    = strReg;
        nextLen    = lenReg;
        nextOffset = offset;
        nextHold   = holdCnt;
        wrapEvt    = 1'b0;
        revZeroEvt = 1'b0;

        // One forward step: loop mode wraps at the period, the others stop at the last offset.
        fwdOffset = offset + 1'b1;
        fwdState  = ST_SCROLL;
        fwdWrap   = 1'b0;
        if (modeReg == MODE_LOOP) begin
            if (fwdOffset == period) begin
                fwdOffset = '0;
                fwdWrap   = 1'b1;
            end
        end else if (fwdOffset == lastOff) begin
            fwdState = ST_END_HOLD;
        end

        if (loadFire) begin
            nextStr    = bus.load_str;
            nextLen    = clampLen;
            nextMode   = normMode(bus.load_mode);
            nextOffset = '0;
            nextHold   = '0;
            if (clampLen == '0)          nextState = ST_IDLE;
            else if (clampLen <= WinLen) nextState = ST_STATIC;
            else                         nextState = ST_LEAD_HOLD;
        end else if (step) begin
            case (state)
                ST_LEAD_HOLD: begin
                    if (holdCnt == LastHold) begin
                        nextHold   = '0;
                        nextOffset = fwdOffset;
                        nextState  = fwdState;
                        wrapEvt    = fwdWrap;
                    end else begin
                        nextHold = holdCnt + 1'b1;
                    end
                end
                ST_SCROLL: begin
                    nextOffset = fwdOffset;
                    nextState  = fwdState;
                    wrapEvt    = fwdWrap;
                end
                ST_END_HOLD: begin
                    if (holdCnt == LastHold) begin
                        nextHold  = '0;
                        nextState = ST_DONE;
`ifdef SCROLL_PINGPONG_EN
                        if (modeReg == MODE_PINGPONG) begin
                            nextOffset = offset - 1'b1;
                            if (offset == OffW'(1)) begin
                                nextState  = ST_START_HOLD;
                                revZeroEvt = 1'b1;
                            end else begin
                                nextState = ST_REV_SCROLL;
                            end
                        end
`endif
                    end else begin
                        nextHold = holdCnt + 1'b1;
                    end
                end
`ifdef SCROLL_PINGPONG_EN
                ST_REV_SCROLL: begin
                    nextOffset = offset - 1'b1;
                    if (offset == OffW'(1)) begin
                        nextState  = ST_START_HOLD;
                        revZeroEvt = 1'b1;
                    end
                end
                ST_START_HOLD: begin
                    if (holdCnt == LastHold) begin
                        nextHold   = '0;
                        nextOffset = fwdOffset;
                        nextState  = fwdState;
                    end else begin
                        nextHold = holdCnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Next window contents, busy and done, computed from the next-state values.
    always_comb begin
        winNext    = '0;
        srcIdx     = '0;
        chr        = BLANK_CHAR;
        nextPeriod = (nextMode == MODE_LOOP) ? OffW'(nextLen) + OffW'(GAP_CHARS) : OffW'(nextLen);

        for (int i = 0; i < WIN_CHARS; i++) begin
            chr = BLANK_CHAR;
            if (nextState == ST_STATIC) begin
                // Right-justify a short string behind leading blanks.
                srcIdx = IdxW'(i) + IdxW'(nextLen);
                if (srcIdx >= WinIdx) chr = charAt(nextStr, srcIdx - WinIdx);
            end else begin
                srcIdx = IdxW'(nextOffset) + IdxW'(i);
                if (srcIdx >= IdxW'(nextPeriod)) srcIdx = srcIdx - IdxW'(nextPeriod);
                if (srcIdx < IdxW'(nextLen)) chr = charAt(nextStr, srcIdx);
            end
            winNext[(WIN_CHARS-1-i)*8 +: 8] = chr;
        end

        busyNext = (nextState == ST_LEAD_HOLD) || (nextState == ST_SCROLL) || (nextState == ST_END_HOLD);
`ifdef SCROLL_PINGPONG_EN
        busyNext = busyNext || (nextState == ST_REV_SCROLL) || (nextState == ST_START_HOLD);
`endif
        doneNext = ((nextState == ST_DONE) && (state != ST_DONE)) || wrapEvt || revZeroEvt;
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            winReg  <= {WIN_CHARS{BLANK_CHAR}};
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            winReg  <= winNext;
            busyReg <= busyNext;
            doneReg <= doneNext;
        end
    end

    assign bus.load_ready  = readyReg;
    assign bus.win_ascii   = winReg;
    assign bus.busy        = busyReg;
    assign bus.scroll_done = doneReg;

endmodule

// File: tb/tb_scroll_window_display.sv
// Directed bench for scroll_window_display (BUF 10, WIN 4, STEP 4, HOLD 2, GAP 2).
// Covers SCROLL_PINGPONG_EN when the macro is defined.
module tb_scroll_window_display;

    localparam int BUF_C  = 10;
    localparam int WIN_C  = 4;
    localparam int STEP_C = 4;
    localparam int HOLD_C = 2;
    localparam int GAP_C  = 2;

    localparam logic [79:0] DIGITS = "0123456789";
    localparam logic [31:0] BLANKS = 32'h20202020;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    scroll_window_display_if #(.BUF_CHARS(BUF_C), .WIN_CHARS(WIN_C)) bus ();

    scroll_window_display #(
        .BUF_CHARS  (BUF_C),
        .WIN_CHARS  (WIN_C),
        .STEP_CYCLES(STEP_C),
        .HOLD_STEPS (HOLD_C),
        .GAP_CHARS  (GAP_C),
        .BLANK_CHAR (8'h20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a load for one cycle; returns just after the accepting edge.
    task automatic doLoad(input logic [79:0] s, input logic [3:0] len, input logic [1:0] mode);
        bus.load_valid = 1'b1;
        bus.load_str   = s;
        bus.load_len   = len;
        bus.load_mode  = mode;
        tick();
        bus.load_valid = 1'b0;
    endtask

    // Window, busy and scroll_done=0 must hold for n consecutive samples; observed value is the count of bad samples.
    task automatic holdFor(input string tag, input logic [31:0] expWin, input int n, input logic expBusy);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (bus.win_ascii !== expWin || bus.busy !== expBusy || bus.scroll_done !== 1'b0) bad++;
            tick();
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    function automatic logic [31:0] digitsAt(input int off);
        return {8'(48 + off), 8'(49 + off), 8'(50 + off), 8'(51 + off)};
    endfunction

    // Load the digit string and walk it through lead hold, scroll and end hold.
    task automatic runDigitsForward(input string tag, input logic [3:0] len, input logic [1:0] mode);
        doLoad(DIGITS, len, mode);
        holdFor({tag, " lead 0123"}, 32'h30313233, 8, 1'b1);
        for (int off = 1; off <= 5; off++) holdFor({tag, " scroll"}, digitsAt(off), 4, 1'b1);
        holdFor({tag, " end hold 6789"}, 32'h36373839, 8, 1'b1);
    endtask

    // One-shot completion: single done pulse, busy low, final window retained.
    task automatic expectDone(input string tag);
        check({tag, " done pulse"}, 32'(bus.scroll_done), 32'd1);
        check({tag, " busy low"}, 32'(bus.busy), 32'd0);
        check({tag, " final win"}, bus.win_ascii, 32'h36373839);
        tick();
        check({tag, " done one cycle"}, 32'(bus.scroll_done), 32'd0);
        holdFor({tag, " retained"}, 32'h36373839, 12, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_str   = '0;
        bus.load_len   = '0;
        bus.load_mode  = '0;

        // Reset values
        repeat (3) tick();
        check("reset win", bus.win_ascii, BLANKS);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.scroll_done), 32'd0);
        check("reset ready", 32'(bus.load_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("ready after reset", 32'(bus.load_ready), 32'd1);

        // Short string: static, right-justified
        doLoad({"42", 64'h0}, 4'd2, 2'b00);
        check("static win", bus.win_ascii, 32'h20203432);
        check("static busy", 32'(bus.busy), 32'd0);
        holdFor("static 100 cycles", 32'h20203432, 100, 1'b0);

        // Full-length one-shot
        runDigitsForward("oneshot", 4'd10, 2'b00);
        expectDone("oneshot");

        // Loop mode with gap
        doLoad({"ABCDE", 40'h0}, 4'd5, 2'b01);
        holdFor("loop lead ABCD", 32'h41424344, 8, 1'b1);
        holdFor("loop BCDE", 32'h42434445, 4, 1'b1);
        holdFor("loop CDE_", 32'h43444520, 4, 1'b1);
        holdFor("loop DE__", 32'h44452020, 4, 1'b1);
        holdFor("loop E__A", 32'h45202041, 4, 1'b1);
        holdFor("loop __AB", 32'h20204142, 4, 1'b1);
        holdFor("loop _ABC", 32'h20414243, 4, 1'b1);
        check("loop wrap win", bus.win_ascii, 32'h41424344);
        check("loop wrap done", 32'(bus.scroll_done), 32'd1);
        check("loop wrap busy", 32'(bus.busy), 32'd1);
        tick();
        check("loop done one cycle", 32'(bus.scroll_done), 32'd0);
        holdFor("loop no hold after wrap", 32'h41424344, 3, 1'b1);
        holdFor("loop repeat BCDE", 32'h42434445, 4, 1'b1);
        holdFor("loop repeat CDE_", 32'h43444520, 2, 1'b1);

        // Mid-scroll preemption
        doLoad({"HI", 64'h0}, 4'd2, 2'b00);
        check("preempt win", bus.win_ascii, 32'h20204849);
        check("preempt busy", 32'(bus.busy), 32'd0);
        check("preempt no done", 32'(bus.scroll_done), 32'd0);
        holdFor("preempt stays", 32'h20204849, 20, 1'b0);

        // Zero length
        doLoad(DIGITS, 4'd0, 2'b00);
        check("len0 win", bus.win_ascii, BLANKS);
        check("len0 busy", 32'(bus.busy), 32'd0);
        holdFor("len0 idle", BLANKS, 10, 1'b0);

        // Length clamp
        runDigitsForward("clamp12", 4'd12, 2'b00);
        expectDone("clamp12");

        // Reserved mode and a string one char longer than the window
        doLoad({"ABCDE", 40'h0}, 4'd5, 2'b11);
        holdFor("mode11 lead ABCD", 32'h41424344, 8, 1'b1);
        holdFor("mode11 end BCDE", 32'h42434445, 8, 1'b1);
        check("mode11 done", 32'(bus.scroll_done), 32'd1);
        check("mode11 busy", 32'(bus.busy), 32'd0);
        check("mode11 win", bus.win_ascii, 32'h42434445);
        tick();
        check("mode11 done one cycle", 32'(bus.scroll_done), 32'd0);

        // Mode 10
        runDigitsForward("mode10", 4'd10, 2'b10);
`ifdef SCROLL_PINGPONG_EN
        for (int off = 5; off >= 1; off--) holdFor("pingpong reverse", digitsAt(off), 4, 1'b1);
        check("pingpong back win", bus.win_ascii, 32'h30313233);
        check("pingpong back done", 32'(bus.scroll_done), 32'd1);
        check("pingpong back busy", 32'(bus.busy), 32'd1);
        tick();
        check("pingpong done one cycle", 32'(bus.scroll_done), 32'd0);
        holdFor("pingpong start hold", 32'h30313233, 7, 1'b1);
        holdFor("pingpong forward again", 32'h31323334, 4, 1'b1);
`else
        expectDone("mode10");
`endif

        // Reset mid-scroll
        doLoad(DIGITS, 4'd10, 2'b01);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("midreset win", bus.win_ascii, BLANKS);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.scroll_done), 32'd0);
        check("midreset ready", 32'(bus.load_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("midreset ready after", 32'(bus.load_ready), 32'd1);
        holdFor("midreset idle", BLANKS, 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
